// File: rtl/sha3_row_packer_pkg.sv
// Shared types and lane geometry for the Keccak-f[1600] row packer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package sha3_row_packer_pkg;

  localparam int LANES  = 25;
  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int LANE_W = 64;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  // One row of the 5x5 state; element [c] is column c.
  typedef logic [COLS-1:0][LANE_W-1:0] row_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } xy_t;

  // Map a stream lane index onto its (row, column) position in the state.
  // Column-major order puts x (column) = k/5 and y (row) = k%5.
  function automatic xy_t lane_to_xy(input int k, input bit row_major);
    xy_t r;
    if (row_major) begin
      r.row = 3'(k / COLS);
      r.col = 3'(k % COLS);
    end else begin
      r.col = 3'(k / ROWS);
      r.row = 3'(k % ROWS);
    end
    return r;
  endfunction

endpackage

// File: rtl/i_sha3_1600_row_bus.sv
// Row-wide bus carrying the full 1600-bit state plus a one-cycle sample pulse.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; the receiver stalls via the packer's hold input.
interface i_sha3_1600_row_bus;
  import sha3_row_packer_pkg::*;

  logic sample;
  row_t rowa;
  row_t rowb;
  row_t rowc;
  row_t rowd;
  row_t rowe;

  modport controller (output sample, rowa, rowb, rowc, rowd, rowe);
  modport target     (input  sample, rowa, rowb, rowc, rowd, rowe);
endinterface

// File: rtl/sha3_lane_assembler.sv
// Turns accepted input beats into lane write strobes; builds 64-bit lanes from 32-bit halves.
// Latency: 0 cycles (write strobe in the accepting cycle); IN_WIDTH=64 is a pure passthrough.
// Backpressure: none of its own; beat_vld must already be qualified by the packer's ready.
module sha3_lane_assembler
  import sha3_row_packer_pkg::*;
#(
  parameter int IN_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beat_vld,
  input  logic [IN_WIDTH-1:0] beat_dat,
  input  logic                beat_last,
  output logic [LANE_W-1:0]   wr_dat,
  output logic [1:0]          wr_mask,
  output logic                lane_vld,
  output logic                half
);

  generate
    if (IN_WIDTH == 32) begin : g_half
      logic half_q;

      // Half flag: set after a low-half beat, cleared by the high half or by an early last.
      always_ff @(posedge clk) begin
        if (rst) begin
          half_q <= 1'b0;
        end else if (beat_vld) begin
          half_q <= !half_q && !beat_last;
        end
      end

      // A low-half beat carrying last also zeroes the upper half of the same lane.
      assign half     = half_q;
      assign wr_dat   = half_q ? {beat_dat, 32'b0} : {32'b0, beat_dat};
      assign wr_mask  = {half_q | beat_last, ~half_q};
      assign lane_vld = beat_vld && (half_q || beat_last);
    end else begin : g_full
      logic unused_full;

      assign unused_full = ^{clk, rst, beat_last};
      assign half        = 1'b0;
      assign wr_dat      = beat_dat;
      assign wr_mask     = 2'b11;
      assign lane_vld    = beat_vld;
    end
  endgenerate

endmodule

// File: rtl/sha3_row_packer.sv
// Packs a lane stream into the 5x5 Keccak state and hands it over with a one-cycle sample.
// Latency: sample rises the cycle after the completing beat (hold=0); stalls in WAIT while hold=1.
// Backpressure: in_ready is high only in FILL; optional early completion via SHA3_ROW_PACKER_ZERO_FILL_EN.
module sha3_row_packer
  import sha3_row_packer_pkg::*;
#(
  parameter int IN_WIDTH             = 64,
  parameter bit LANE_ORDER_ROW_MAJOR = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic                          hold,
  i_sha3_1600_row_bus.controller        dst,
  output logic                          busy
);

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        cnt;
  logic              sample_q;
  logic [LANE_W-1:0] lanes [LANES];
  row_t              rows [ROWS];
  xy_t               xy;

  logic              accept;
  logic              last_eff;
  logic              complete;
  logic [LANE_W-1:0] wr_dat;
  logic [1:0]        wr_mask;
  logic              lane_vld;
  logic              half;

`ifdef SHA3_ROW_PACKER_ZERO_FILL_EN
  assign last_eff = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_eff       = 1'b0;
`endif

  assign in_ready = (state == FILL) && !rst;
  assign accept   = in_valid && in_ready;

  sha3_lane_assembler #(.IN_WIDTH(IN_WIDTH)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .beat_vld  (accept),
    .beat_dat  (in_data),
    .beat_last (last_eff),
    .wr_dat    (wr_dat),
    .wr_mask   (wr_mask),
    .lane_vld  (lane_vld),
    .half      (half)
  );

  // A block completes on lane 24, or earlier on a last beat when zero fill is built in.
  assign complete = lane_vld && ((cnt == 5'd24) || last_eff);

  // Next-state logic: hold is sampled at completion and in WAIT, never in EMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (complete) state_nxt = hold ? WAIT : EMIT;
      WAIT:    if (!hold) state_nxt = EMIT;
      EMIT:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // State, lane counter and the registered sample pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= 5'd0;
      sample_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      sample_q <= (state_nxt == EMIT);
      if (lane_vld) begin
        cnt <= complete ? 5'd0 : cnt + 5'd1;
      end
    end
  end

  // Lane array: masked half/full write at the counter, zero fill above it on early completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) lanes[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (accept && (cnt == 5'(k))) begin
          if (wr_mask[0]) lanes[k][31:0]  <= wr_dat[31:0];
          if (wr_mask[1]) lanes[k][63:32] <= wr_dat[63:32];
        end else if (lane_vld && last_eff && (5'(k) > cnt)) begin
          lanes[k] <= '0;
        end
      end
    end
  end

  // Route each lane register to its row/column slot on the bus.
  always_comb begin
    xy = '0;
    for (int r = 0; r < ROWS; r++) rows[r] = '0;
    for (int k = 0; k < LANES; k++) begin
      xy = lane_to_xy(k, LANE_ORDER_ROW_MAJOR);
      rows[xy.row][xy.col] = lanes[k];
    end
  end

  assign dst.sample = sample_q;
  assign dst.rowa   = rows[0];
  assign dst.rowb   = rows[1];
  assign dst.rowc   = rows[2];
  assign dst.rowd   = rows[3];
  assign dst.rowe   = rows[4];

  assign busy = (state != FILL) || (cnt != 5'd0) || half;

endmodule

// File: tb/tb_sha3_row_packer.sv
// Bench for sha3_row_packer: a 64-bit row-major instance and a 32-bit column-major instance.
// Stimulus drivers push expected states into per-instance queues; negedge monitors pop and compare.
// Zero-fill scenarios are compiled in only when SHA3_ROW_PACKER_ZERO_FILL_EN is defined.
module tb_sha3_row_packer;
  import sha3_row_packer_pkg::*;

  typedef logic [24:0][63:0] st_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] d64 = '0;
  logic [31:0] d32 = '0;
  logic        v64 = 1'b0, v32 = 1'b0;
  logic        last64 = 1'b0, last32 = 1'b0;
  logic        hold64 = 1'b0, hold32 = 1'b0;
  logic        rdy64, rdy32, busy64, busy32;

  i_sha3_1600_row_bus bus64 ();
  i_sha3_1600_row_bus bus32 ();

  sha3_row_packer #(.IN_WIDTH(64), .LANE_ORDER_ROW_MAJOR(1'b1)) u64 (
    .clk(clk), .rst(rst), .in_data(d64), .in_valid(v64), .in_ready(rdy64),
    .in_last(last64), .hold(hold64), .dst(bus64), .busy(busy64));

  sha3_row_packer #(.IN_WIDTH(32), .LANE_ORDER_ROW_MAJOR(1'b0)) u32 (
    .clk(clk), .rst(rst), .in_data(d32), .in_valid(v32), .in_ready(rdy32),
    .in_last(last32), .hold(hold32), .dst(bus32), .busy(busy32));

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  st_t  q64[$];
  st_t  q32[$];
  int   samp64[$];
  st_t  cur [2];
  int   bn  [2];
  st_t  exp64, got64, exp32, got32;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference placement: row-major (k/5, k%5), column-major row=k%5, col=k/5.
  function automatic st_t gather(input row_t r0, input row_t r1, input row_t r2,
                                 input row_t r3, input row_t r4, input bit rm);
    row_t rr [5];
    st_t  g;
    rr = '{r0, r1, r2, r3, r4};
    for (int k = 0; k < 25; k++) g[k] = rm ? rr[k / 5][k % 5] : rr[k % 5][k / 5];
    return g;
  endfunction

  task automatic compare_state(input string name, input st_t got, input st_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      for (int k = 0; k < 25; k++) begin
        if (got[k] !== want[k]) begin
          $display("FAIL %s: lane %0d got %h, expected %h", name, k, got[k], want[k]);
          break;
        end
      end
    end
  endtask

  // Monitors: every sample pulse must match the oldest outstanding expected state.
  always @(negedge clk) begin
    if (bus64.sample === 1'b1) begin
      samp64.push_back(cyc);
      if (q64.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sample64_unexpected: got sample=1, expected 0 at cycle %0d", cyc);
      end else begin
        exp64 = q64.pop_front();
        got64 = gather(bus64.rowa, bus64.rowb, bus64.rowc, bus64.rowd, bus64.rowe, 1'b1);
        compare_state("state64", got64, exp64);
      end
    end
  end

  always @(negedge clk) begin
    if (bus32.sample === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sample32_unexpected: got sample=1, expected 0 at cycle %0d", cyc);
      end else begin
        exp32 = q32.pop_front();
        got32 = gather(bus32.rowa, bus32.rowb, bus32.rowc, bus32.rowd, bus32.rowe, 1'b0);
        compare_state("state32", got32, exp32);
      end
    end
  end

  // Behavioural model: lanes fill in stream order, contents persist across blocks,
  // an early last zeroes every later lane (and the open upper half at 32 bits).
  task automatic model_beat(input int u, input logic [63:0] d, input logic last);
    int lane;
    bit hi;
    bit zf;
    bit done;
`ifdef SHA3_ROW_PACKER_ZERO_FILL_EN
    zf = last;
`else
    zf = 1'b0;
`endif
    if (u == 0) begin
      lane = bn[0];
      cur[0][lane] = d;
      done = zf || (lane == 24);
    end else begin
      lane = bn[1] / 2;
      hi   = (bn[1] % 2) == 1;
      if (hi) cur[1][lane][63:32] = d[31:0];
      else begin
        cur[1][lane][31:0] = d[31:0];
        if (zf) cur[1][lane][63:32] = '0;
      end
      done = zf || (hi && lane == 24);
    end
    if (done) begin
      if (zf) for (int j = lane + 1; j < 25; j++) cur[u][j] = '0;
      if (u == 0) q64.push_back(cur[0]);
      else        q32.push_back(cur[1]);
      bn[u] = 0;
    end else begin
      bn[u] = bn[u] + 1;
    end
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? rdy64 : rdy32;
  endfunction

  // Present one beat from the next falling edge and hold it until it is accepted.
  task automatic send(input int u, input logic [63:0] d, input logic last);
    int budget = 200;
    @(negedge clk);
    if (u == 0) begin v64 = 1'b1; d64 = d; last64 = last; end
    else begin v32 = 1'b1; d32 = d[31:0]; last32 = last; end
    #1;
    while (!rdy(u) && budget > 0) begin
      @(negedge clk); #1; budget--;
    end
    if (budget == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
    end else begin
      @(posedge clk);
      model_beat(u, d, last);
    end
  endtask

  task automatic idle(input int u, input int n);
    repeat (n) begin
      @(negedge clk);
      if (u == 0) v64 = 1'b0; else v32 = 1'b0;
      last64 = 1'b0; last32 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v64 = 1'b1;
    d64 = 64'hDEAD;
    cur[0] = '0; cur[1] = '0; bn[0] = 0; bn[1] = 0;
    #1;
    check("ready_in_rst", rdy64, 0);
    @(negedge clk);
    rst = 1'b0;
    v64 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cur[0] = '0; cur[1] = '0; bn[0] = 0; bn[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", rdy64, 0);
    check("rst_sample", bus64.sample, 0);
    check("rst_busy", busy64, 0);
    check("rst_rows", |{bus64.rowa, bus64.rowb, bus64.rowc, bus64.rowd, bus64.rowe}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy64, 1);

    // Basic block, data k+1, sample exactly the cycle after the last beat.
    for (int k = 0; k < 25; k++) send(0, 64'(k + 1), 1'b0);
    @(negedge clk); #1;
    v64 = 1'b0;
    check("t1_sample", bus64.sample, 1);
    check("t1_ready_emit", rdy64, 0);
    check("t1_rowa0", bus64.rowa[0], 64'd1);
    check("t1_rowa4", bus64.rowa[4], 64'd5);
    check("t1_rowe4", bus64.rowe[4], 64'd25);
    @(negedge clk); #1;
    check("t1_sample_drop", bus64.sample, 0);

    // Hold toggling in FILL is ignored; hold high at completion stalls for 7 cycles.
    for (int k = 0; k < 25; k++) begin
      hold64 = (k >= 20) ? 1'b1 : 1'($urandom_range(1, 0));
      send(0, 64'(k + 1), 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      v64 = 1'b0;
      check("t2_ready_hold", rdy64, 0);
      check("t2_sample_hold", bus64.sample, 0);
    end
    @(negedge clk);
    hold64 = 1'b0;
    @(negedge clk); #1;
    check("t2_sample_release", bus64.sample, 1);
    check("t2_rowc2", bus64.rowc[2], 64'd13);

    // Random gaps, reset after lane 12: nothing emitted, rows cleared.
    for (int k = 0; k <= 12; k++) begin
      send(0, {$urandom, $urandom}, 1'b0);
      idle(0, $urandom_range(2, 0));
    end
    do_reset();
    #1;
    check("t3_rows_zero", |{bus64.rowa, bus64.rowb, bus64.rowc, bus64.rowd, bus64.rowe}, 0);
    check("t3_busy", busy64, 0);
    for (int k = 0; k < 25; k++) begin
      send(0, {$urandom, $urandom}, 1'b0);
      idle(0, $urandom_range(2, 0));
    end
    idle(0, 3);

    // Back-to-back blocks: sample pulses 26 cycles apart.
    samp64.delete();
    for (int k = 0; k < 50; k++) send(0, {$urandom, $urandom}, 1'b0);
    idle(0, 3);
    if (samp64.size() == 2) check("t4_period", 64'(samp64[1] - samp64[0]), 64'd26);
    else check("t4_pulse_count", 64'(samp64.size()), 64'd2);

    // 32-bit, column-major: each lane {BBBB0000+i, AAAA0000+i} after 50 beats.
    for (int i = 0; i < 25; i++) begin
      send(1, 64'(32'hAAAA0000 + i), 1'b0);
      send(1, 64'(32'hBBBB0000 + i), 1'b0);
    end
    @(negedge clk); #1;
    v32 = 1'b0;
    check("t5_sample", bus32.sample, 1);
    check("t5_lane1", bus32.rowb[0], 64'hBBBB0001_AAAA0001);
    check("t5_lane24", bus32.rowe[4], 64'hBBBB0018_AAAA0018);
    idle(1, 2);

`ifdef SHA3_ROW_PACKER_ZERO_FILL_EN
    // Early completion on lane 3 zeroes the rest of the state.
    for (int k = 0; k < 4; k++) send(0, 64'hFF, (k == 3));
    @(negedge clk); #1;
    v64 = 1'b0; last64 = 1'b0;
    check("t6_sample", bus64.sample, 1);
    check("t6_rowa3", bus64.rowa[3], 64'hFF);
    check("t6_rowa4", bus64.rowa[4], 64'h0);
    check("t6_rowe4", bus64.rowe[4], 64'h0);
    idle(0, 2);
    // Last on a low half zeroes that lane's upper half and everything after it.
    for (int i = 0; i < 5; i++) send(1, 64'(32'h1234_0000 + i), (i == 4));
    @(negedge clk); #1;
    v32 = 1'b0; last32 = 1'b0;
    check("t6_sample32", bus32.sample, 1);
    check("t6_lane2_32", bus32.rowc[0], 64'h0000_0000_1234_0004);
    idle(1, 2);
`endif

    idle(0, 3);
    check("q64_drained", 64'(q64.size()), 64'd0);
    check("q32_drained", 64'(q32.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
